// File: rtl/vga_line_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch_if
// Purpose  : Beam position, frame-memory read port and pixel output bundle
//            of the VGA line prefetcher.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_line_prefetch_if #(
  parameter int ADDR_W = 18
);
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              video_on;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        pixel_color;
  logic              pixel_valid;
  logic              fetch_busy;
  logic              underrun;

  // Prefetcher side
  modport slave (
    input  pixel_x, pixel_y, video_on, mem_data,
    output mem_addr, pixel_color, pixel_valid, fetch_busy, underrun
  );

  // Beam generator / memory / printer side
  modport master (
    output pixel_x, pixel_y, video_on, mem_data,
    input  mem_addr, pixel_color, pixel_valid, fetch_busy, underrun
  );
endinterface
`default_nettype wire

// File: rtl/vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch
// Purpose  : Fetches one image row per display line into a ping-pong line
//            buffer one line ahead of the beam and serves pixels from it.
//            Image row r always lives in buffer r[0].
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_prefetch #(
  parameter int                IMG_W     = 256,
  parameter int                IMG_H     = 256,
  parameter int                X0        = 192,
  parameter int                Y0        = 112,
  parameter int                ADDR_W    = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MEM_LAT   = 1
) (
  input  wire logic          vga_clk,
  input  wire logic          rst,
  vga_line_prefetch_if.slave bus
);

  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_DC_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state, w_state_nx;
  logic [c_COL_W-1:0]   r_col, w_col_nx;
  logic [c_ROW_W-1:0]   r_tr, w_tr_nx;
  logic [c_DC_W-1:0]    r_dcnt, w_dcnt_nx;
  logic                 w_tag_clr, w_tag_set;

  logic [1:0]           r_tagv;
  logic [c_ROW_W-1:0]   r_tag [2];

  logic                 r_pv [MEM_LAT];
  logic [c_COL_W-1:0]   r_pc [MEM_LAT];

  logic [7:0]           r_ram [2*IMG_W];
  logic [7:0]           r_rd;
  logic                 r_valid;
  logic                 r_und;

  // Fetch trigger: start of a line whose successor is an image row
  logic [10:0]          w_ny;
  logic                 w_trig;
  logic [c_ROW_W-1:0]   w_trow;

  assign w_ny   = {1'b0, bus.pixel_y} + 11'd1;
  assign w_trig = (bus.pixel_x == 10'd0) && (w_ny >= 11'(Y0)) && (w_ny < 11'(Y0 + IMG_H));
  assign w_trow = c_ROW_W'(w_ny - 11'(Y0));

  // Display window and tag match for the row under the beam
  logic [10:0]          w_x11, w_y11;
  logic                 w_win, w_hit;
  logic [c_ROW_W-1:0]   w_row;
  logic [c_COL_W-1:0]   w_xo;

  assign w_x11 = {1'b0, bus.pixel_x};
  assign w_y11 = {1'b0, bus.pixel_y};
  assign w_win = bus.video_on
              && (w_x11 >= 11'(X0)) && (w_x11 < 11'(X0 + IMG_W))
              && (w_y11 >= 11'(Y0)) && (w_y11 < 11'(Y0 + IMG_H));
  assign w_row = c_ROW_W'(bus.pixel_y - 10'(Y0));
  assign w_xo  = c_COL_W'(bus.pixel_x - 10'(X0));
  assign w_hit = w_win && r_tagv[w_row[0]] && (r_tag[w_row[0]] == w_row);

  // Row-times-width is a plain concatenation since IMG_W is a power of two
  logic [ADDR_W-1:0]    w_addr;
  assign w_addr = BASE_ADDR + ADDR_W'({r_tr, r_col});

  // FSM state and fetch counters
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_tr    <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_tr    <= w_tr_nx;
      r_dcnt  <= w_dcnt_nx;
    end
  end

  // FSM next state: issue IMG_W addresses, then wait out the read latency
  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_tr_nx    = r_tr;
    w_dcnt_nx  = r_dcnt;
    w_tag_clr  = 1'b0;
    w_tag_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_tr_nx    = w_trow;
          w_col_nx   = '0;
          w_tag_clr  = 1'b1;
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        w_col_nx = r_col + c_COL_W'(1);
        if (r_col == c_COL_W'(IMG_W - 1)) begin
          w_dcnt_nx  = '0;
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_dcnt_nx = r_dcnt + c_DC_W'(1);
        if (r_dcnt == c_DC_W'(MEM_LAT - 1)) begin
          w_tag_set  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Row tags: invalidated when a refill starts, published once the last byte lands
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_tagv   <= 2'b00;
      r_tag[0] <= '0;
      r_tag[1] <= '0;
    end else begin
      if (w_tag_clr) r_tagv[w_trow[0]] <= 1'b0;
      if (w_tag_set) begin
        r_tagv[r_tr[0]] <= 1'b1;
        r_tag[r_tr[0]]  <= r_tr;
      end
    end
  end

  // Read-latency pipeline pairing each returning byte with its column
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pc[i] <= '0;
      end
    end else begin
      r_pv[0] <= (r_state == S_REQ);
      r_pc[0] <= r_col;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
      end
    end
  end

  // Line buffer RAM: one fill port, one registered display read port
  always_ff @(posedge vga_clk) begin
    if (r_pv[MEM_LAT-1]) r_ram[{r_tr[0], r_pc[MEM_LAT-1]}] <= bus.mem_data;
    r_rd <= r_ram[{w_row[0], w_xo}];
  end

  // Pixel qualifier and sticky underrun (display miss or refill overlap)
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_und   <= 1'b0;
    end else begin
      r_valid <= w_hit;
      if ((w_win && !w_hit) || (w_trig && (r_state != S_IDLE))) r_und <= 1'b1;
    end
  end

  assign bus.mem_addr    = (r_state == S_REQ) ? w_addr : BASE_ADDR;
  assign bus.pixel_color = r_valid ? r_rd : 8'd0;
  assign bus.pixel_valid = r_valid;
  assign bus.fetch_busy  = (r_state != S_IDLE);
  assign bus.underrun    = r_und;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_line_prefetch
// Purpose  : Self-checking bench for two prefetchers (base 0 / latency 1 and
//            base 18'h3FF00 / latency 2) sharing one beam, compared against a
//            fetch-timeline model, plus hand-computed anchor values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_line_prefetch;

  localparam int W  = 256;
  localparam int H  = 256;
  localparam int X0 = 192;
  localparam int Y0 = 112;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic       von = 1'b0;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_line_prefetch_if #(.ADDR_W(18)) if0 ();
  vga_line_prefetch_if #(.ADDR_W(18)) if1 ();

  assign if0.pixel_x = px;  assign if0.pixel_y = py;  assign if0.video_on = von;
  assign if1.pixel_x = px;  assign if1.pixel_y = py;  assign if1.video_on = von;

  vga_line_prefetch #(.BASE_ADDR(18'h00000), .MEM_LAT(1)) dut0 (
    .vga_clk(clk), .rst(rst_n), .bus(if0));
  vga_line_prefetch #(.BASE_ADDR(18'h3FF00), .MEM_LAT(2)) dut1 (
    .vga_clk(clk), .rst(rst_n), .bus(if1));

  // Frame memory content as a function of the address
  function automatic logic [7:0] memf(input logic [17:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic int mlat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic [17:0] basek(input int k);
    return (k == 0) ? 18'h00000 : 18'h3FF00;
  endfunction

  function automatic logic [17:0] maddr(input int k, input int row, input int col);
    return basek(k) + 18'(row * W + col);
  endfunction

  // Memories answering MEM_LAT cycles after the address
  logic [7:0] md0, md1a, md1b;
  always @(posedge clk) begin
    md0  <= memf(if0.mem_addr);
    md1a <= memf(if1.mem_addr);
    md1b <= md1a;
  end
  assign if0.mem_data = md0;
  assign if1.mem_data = md1b;

  logic [17:0] o_addr [2];
  logic [7:0]  o_col  [2];
  logic        o_val  [2];
  logic        o_busy [2];
  logic        o_und  [2];
  assign o_addr[0] = if0.mem_addr;    assign o_addr[1] = if1.mem_addr;
  assign o_col[0]  = if0.pixel_color; assign o_col[1]  = if1.pixel_color;
  assign o_val[0]  = if0.pixel_valid; assign o_val[1]  = if1.pixel_valid;
  assign o_busy[0] = if0.fetch_busy;  assign o_busy[1] = if1.fetch_busy;
  assign o_und[0]  = if0.underrun;    assign o_und[1]  = if1.underrun;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: one fetch record per DUT, tags per buffer, expected next pixel
  longint cyc = 0;
  bit     m_fetch [2];
  longint m_t     [2];
  longint m_e     [2];
  int     m_tr    [2];
  bit     m_tagv  [2][2];
  int     m_tag   [2][2];
  bit     m_und   [2];
  bit     m_ev    [2];
  logic [7:0] m_ec [2];

  // Compare every cycle, then advance the model with this cycle's inputs
  always @(negedge clk) begin : model
    int xi, yi, r, b, ny;
    bit win, hit;
    cyc++;
    xi = int'(px);
    yi = int'(py);
    for (int k = 0; k < 2; k++) begin
      if (m_fetch[k] && cyc >= m_e[k]) begin
        m_fetch[k] = 1'b0;
        m_tagv[k][m_tr[k] % 2] = 1'b1;
        m_tag[k][m_tr[k] % 2]  = m_tr[k];
      end
      if (!rst_n) begin
        chk("rst_addr",  k, 32'(o_addr[k]), 32'(basek(k)));
        chk("rst_color", k, 32'(o_col[k]),  32'd0);
        chk("rst_valid", k, 32'(o_val[k]),  32'd0);
        chk("rst_busy",  k, 32'(o_busy[k]), 32'd0);
        chk("rst_und",   k, 32'(o_und[k]),  32'd0);
        m_fetch[k] = 1'b0;
        m_tagv[k][0] = 1'b0;
        m_tagv[k][1] = 1'b0;
        m_und[k] = 1'b0;
        m_ev[k]  = 1'b0;
        m_ec[k]  = 8'd0;
      end else begin
        chk("color", k, 32'(o_col[k]),  32'(m_ec[k]));
        chk("valid", k, 32'(o_val[k]),  32'(m_ev[k]));
        chk("busy",  k, 32'(o_busy[k]), 32'(m_fetch[k]));
        chk("und",   k, 32'(o_und[k]),  32'(m_und[k]));
        if (m_fetch[k] && cyc <= m_t[k] + W)
          chk("addr", k, 32'(o_addr[k]), 32'(maddr(k, m_tr[k], int'(cyc - m_t[k] - 1))));
        win = von && xi >= X0 && xi < X0 + W && yi >= Y0 && yi < Y0 + H;
        r   = yi - Y0;
        b   = (r >= 0) ? r % 2 : 0;
        hit = win && m_tagv[k][b] && m_tag[k][b] == r;
        m_ev[k] = hit;
        m_ec[k] = hit ? memf(maddr(k, r, xi - X0)) : 8'd0;
        if (win && !hit) m_und[k] = 1'b1;
        ny = yi + 1;
        if (xi == 0 && ny >= Y0 && ny < Y0 + H) begin
          if (m_fetch[k]) m_und[k] = 1'b1;
          else begin
            m_fetch[k] = 1'b1;
            m_t[k]  = cyc;
            m_tr[k] = ny - Y0;
            m_e[k]  = cyc + W + mlat(k) + 1;
            m_tagv[k][m_tr[k] % 2] = 1'b0;
          end
        end
      end
    end
  end

  // Hand-computed anchors; outputs seen here belong to the previous beam position
  task automatic lit(input int ph, input int x, input int y);
    if (ph == 1) begin
      if (y == 111 && x == 1)   begin @(negedge clk); chk("l_addr_first", 0, 32'(o_addr[0]), 32'h0); end
      if (y == 111 && x == 256) begin @(negedge clk); chk("l_addr_last", 0, 32'(o_addr[0]), 32'hFF); end
      if (y == 111 && x == 257) begin @(negedge clk); chk("l_busy_257", 0, 32'(o_busy[0]), 32'd1); end
      if (y == 111 && x == 258) begin @(negedge clk); chk("l_busy_258", 0, 32'(o_busy[0]), 32'd0); end
      if (y == 112 && x == 1)   begin @(negedge clk); chk("l_wrap_first", 1, 32'(o_addr[1]), 32'h0); end
      if (y == 112 && x == 256) begin @(negedge clk); chk("l_wrap_last", 1, 32'(o_addr[1]), 32'hFF); end
      if (y == 112 && x == 192) begin @(negedge clk); chk("l_x191_valid", 0, 32'(o_val[0]), 32'd0); end
      if (y == 112 && x == 198) begin
        @(negedge clk);
        chk("l_r112_color", 0, 32'(o_col[0]), 32'd5);
        chk("l_r112_valid", 0, 32'(o_val[0]), 32'd1);
        chk("l_r112_color", 1, 32'(o_col[1]), 32'hFA);
      end
      if (y == 112 && x == 449) begin
        @(negedge clk);
        chk("l_x448_valid", 0, 32'(o_val[0]), 32'd0);
        chk("l_x448_color", 0, 32'(o_col[0]), 32'd0);
      end
      if (y == 113 && x == 203) begin
        @(negedge clk);
        chk("l_r113_color", 0, 32'(o_col[0]), 32'd11);
        chk("l_r113_color", 1, 32'(o_col[1]), 32'd10);
      end
      if (y == 114 && x == 799) begin
        @(negedge clk);
        chk("l_pp_und", 0, 32'(o_und[0]), 32'd0);
        chk("l_pp_und", 1, 32'(o_und[1]), 32'd0);
      end
    end else if (ph == 2) begin
      if (y == 150 && x == 401) begin
        @(negedge clk);
        chk("l_r150_valid", 0, 32'(o_val[0]), 32'd0);
        chk("l_r150_und", 0, 32'(o_und[0]), 32'd1);
      end
      if (y == 151 && x == 300) begin @(negedge clk); chk("l_r151_valid", 0, 32'(o_val[0]), 32'd0); end
      if (y == 152 && x == 203) begin
        @(negedge clk);
        chk("l_r152_color", 0, 32'(o_col[0]), 32'd34);
        chk("l_r152_valid", 0, 32'(o_val[0]), 32'd1);
        chk("l_r152_und", 0, 32'(o_und[0]), 32'd1);
        chk("l_r152_color", 1, 32'(o_col[1]), 32'h2D);
      end
    end else if (ph == 3) begin
      if (y == 367 && x == 5)   begin @(negedge clk); chk("l_last_nofetch", 0, 32'(o_busy[0]), 32'd0); end
      if (y == 367 && x == 203) begin @(negedge clk); chk("l_r367_color", 0, 32'(o_col[0]), 32'hF5); end
      if (y == 368 && x == 200) begin @(negedge clk); chk("l_r368_valid", 0, 32'(o_val[0]), 32'd0); end
    end
  endtask

  // Raster scan from (x0,y0) for n cycles; optional reset release and video_on dropouts
  task automatic scan(input int y0, input int x0, input int n, input int ph, input bit rel, input bit rnd);
    int x, y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rel && i == 0) rst_n = 1'b1;
      px  = 10'(x);
      py  = 10'(y);
      von = (x < 640) && (y < 480) && !(rnd && $urandom_range(0, 31) == 0);
      lit(ph, x, y);
      x++;
      if (x == 800) begin
        x = 0;
        y++;
        if (y == 525) y = 0;
      end
    end
  endtask

  initial begin
    // Reset held while the beam inputs toggle
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      px  = 10'($urandom_range(0, 799));
      py  = 10'($urandom_range(0, 524));
      von = 1'($urandom_range(0, 1));
    end
    // First fetch, display and ping-pong over rows 111..114
    scan(110, 790, 10 + 4 * 800, 1, 1'b1, 1'b0);
    // Reset mid-frame, released at row 150 x=300
    @(posedge clk); #1 rst_n = 1'b0;
    scan(149, 700, 400, 0, 1'b0, 1'b0);
    scan(150, 300, 2100, 2, 1'b1, 1'b0);
    // Last image rows and the end of the window
    scan(365, 0, 4 * 800, 3, 1'b0, 1'b0);
    // Vertical blanking and frame wrap
    scan(523, 0, 2000, 0, 1'b0, 1'b1);
    // Random beam jumps, dropouts and resets
    for (int s = 0; s < 8; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1 rst_n = 1'b0;
        scan($urandom_range(108, 372), $urandom_range(0, 799), $urandom_range(1, 4), 0, 1'b0, 1'b1);
        scan($urandom_range(108, 372), $urandom_range(0, 799), $urandom_range(400, 3000), 0, 1'b1, 1'b1);
      end else begin
        scan($urandom_range(108, 372), $urandom_range(0, 799), $urandom_range(400, 3000), 0, 1'b0, 1'b1);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_line_prefetch.md
# vga_line_prefetch

Line-buffered pixel prefetcher in the VGA clock domain, placed between the processor's VGA read port on data memory and the pixel printer. It reads one 256-pixel, 8-bit grayscale image row per line from memory into a ping-pong line buffer, one line ahead of the beam. While the beam is inside the image window, it serves `pixel_color` from the buffer, so the pixel printer never waits on memory.

## Interface
- `IMG_W`, 256: image width in pixels (power of two).
- `IMG_H`, 256: image height in rows.
- `X0`, 192: first display column of the image window.
- `Y0`, 112: first display row of the image window (must be ≥1).
- `BASE_ADDR`, 0: memory address of image pixel (0,0).
- `ADDR_W`, 18: memory address width.
- `MEM_LAT`, 1: cycles from `mem_addr` to the matching `mem_data` (≥1).

Ports:
- `vga_clk` in 1: single clock for the whole block (25 MHz pixel clock).
- `rst` in 1: asynchronous, active-low reset.
- `pixel_x` in 10: current beam column, 0..799.
- `pixel_y` in 10: current beam row, 0..524.
- `video_on` in 1: beam is in the visible 640x480 area.
- `mem_addr` out ADDR_W: read address to frame memory.
- `mem_data` in 8: read data, valid MEM_LAT cycles after the address.
- `pixel_color` out 8: registered grayscale pixel.
- `pixel_valid` out 1: `pixel_color` carries image data.
- `fetch_busy` out 1: a row fetch is in progress.
- `underrun` out 1: sticky error flag, cleared only by `rst`.

## Operation
- Two line buffers, each IMG_W x 8, plus one row tag and one tag-valid bit per buffer.
  - Image row r (r = pixel_y − Y0) is always stored in buffer r[0].
- **Fetch trigger:** pixel_x == 0 on a row y where ny = y+1 satisfies Y0 ≤ ny < Y0+IMG_H. The target row is tr = ny − Y0.
- **FSM states:**
  - IDLE: on trigger, clear tag-valid of buffer tr[0], set col=0, go to REQ.
  - REQ: drive `mem_addr` = BASE_ADDR + tr*IMG_W + col, computed modulo 2^ADDR_W, then col++. After col = IMG_W−1 is issued, go to DRAIN.
  - DRAIN: wait MEM_LAT cycles, then write tag = tr, set tag-valid, go to IDLE.
- **Write path:** a MEM_LAT-deep shift pipeline carries (valid, col). When the delayed valid is high, `mem_data` is written to buffer tr[0] at the delayed col.
- `fetch_busy` = (state ≠ IDLE).
- **Trigger while not IDLE:** the trigger is ignored, the current fetch continues, and `underrun` is set.
- **Display window:** video_on and X0 ≤ pixel_x < X0+IMG_W and Y0 ≤ pixel_y < Y0+IMG_H.
  - If the window condition holds and the active buffer r[0] has tag-valid with tag == r: `pixel_color` = buffer[r[0]][pixel_x − X0] and `pixel_valid` = 1.
  - Inside the window with no tag match: `pixel_color` = 0, `pixel_valid` = 0, and `underrun` is set.
  - Outside the window: `pixel_color` = 0, `pixel_valid` = 0.
- **Simultaneous read and write to the same buffer:** not possible under legal timing. If it does occur, the write wins and the read returns the old or new value (either is acceptable).
- **Reset, including mid-fetch:**
  - State goes to IDLE and both tag-valid bits are cleared.
  - Buffer RAM contents are not cleared.
  - Output reset values: `mem_addr` = BASE_ADDR, `pixel_color` = 0, `pixel_valid` = 0, `fetch_busy` = 0, `underrun` = 0.

## Timing
- **Fetch cycle count:**
  - The trigger is seen at cycle t; the first address appears at t+1.
  - Addresses for col 0..IMG_W−1 appear at t+1..t+IMG_W, one per cycle.
  - Tag-valid is set and `fetch_busy` falls at t+IMG_W+MEM_LAT+1.
  - The total (258 cycles with defaults) fits inside one 800-cycle line.
- **Display latency:** `pixel_color`/`pixel_valid` follow `pixel_x`/`pixel_y` by exactly 1 cycle, through a registered buffer read. The downstream stage delays its sync signals by 1 cycle to match.
- **Frame boundaries:**
  - Image row 0 is fetched during display row Y0−1.
  - No fetch is triggered on the last image row or in vertical blanking.
  - Frame wrap needs no special state.
- **Address arithmetic:** performed in ADDR_W bits with silent wrap-around. Row-times-width is a shift by log2(IMG_W).

## Test plan
- **Reset:** hold `rst`=0 with pixel_x and pixel_y toggling → `mem_addr`=0, `pixel_color`=0, `pixel_valid`=0, `fetch_busy`=0, `underrun`=0 throughout.
- **First fetch:** memory model returns data = addr[7:0] ^ row; drive row 111 from pixel_x=0 → `mem_addr` = 0..255 on cycles 1..256. `fetch_busy` falls at cycle 258 (MEM_LAT=1).
- **Display row 112:**
  - x=192..447 → `pixel_color` = (x−192) ^ 0 one cycle later, with `pixel_valid`=1.
  - x=191 and x=448 → `pixel_color`=0, `pixel_valid`=0.
  - `underrun` stays 0.
- **Ping-pong:** run rows 111..114 back to back → row 113 displays (x−192)^1 while row 114 is fetched into the other buffer. No corruption and `underrun`=0.
- **Reset mid-frame:** release `rst` at row 150, x=300 → image pixels in rows 150 and 151 have `pixel_valid`=0 and `underrun`=1. Row 152 displays correct data, and `underrun` stays 1.
- **Address wrap:** BASE_ADDR=18'h3FF00, fetch row 1 → `mem_addr` sequence runs 18'h00000..18'h000FF.
